// File: rtl/byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
//
// Packs a stream of bytes into 4-lane words. Incoming bytes land in a small
// byte FIFO (the source has no backpressure), then a packer pops them one per
// cycle into lanes 0..3 of an output word. A full word, or a partial word
// closed by a flush request, is presented with valid_o and held stable until
// the consumer accepts it with ready_i.
//
// Parameters
//   SYS_DWIDTH  input byte width (default 8)
//   MST_DWIDTH  output word width, always 4*SYS_DWIDTH
//   FIFO_DEPTH  byte FIFO entries, power of 2, >= 4 (default 16)
//
// Ports
//   clk_sys     system clock, all logic on its rising edge
//   rst_n       synchronous active-low reset
//   data_i      incoming byte
//   valid_i     data_i valid this cycle (no backpressure)
//   flush_i     one-cycle pulse requesting emission of a partial word
//   data_o      packed word, first received byte in lane 0
//   byte_en_o   bit k set when lane k of data_o holds a valid byte
//   valid_o     data_o/byte_en_o valid
//   ready_i     consumer accepts the word when valid_o && ready_i
//   fifo_level  registered FIFO occupancy (only with BYTE_PACKER_LEVEL_EN)
//   overflow    sticky: a byte was dropped because the FIFO was full
//
// Optional feature: define BYTE_PACKER_LEVEL_EN to add the fifo_level port.
// ---------------------------------------------------------------------------
module byte_packer #(
  parameter int SYS_DWIDTH = 8,
  parameter int MST_DWIDTH = 4 * SYS_DWIDTH,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_sys,
  input  logic                          rst_n,
  input  logic [SYS_DWIDTH-1:0]         data_i,
  input  logic                          valid_i,
  input  logic                          flush_i,
  output logic [MST_DWIDTH-1:0]         data_o,
  output logic [3:0]                    byte_en_o,
  output logic                          valid_o,
  input  logic                          ready_i,
`ifdef BYTE_PACKER_LEVEL_EN
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
`endif
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_d;

  logic [SYS_DWIDTH-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [LVL_W-1:0]       level;
  logic [SYS_DWIDTH-1:0]  rd_data;

  logic [MST_DWIDTH-1:0]  word_q;
  logic [3:0]             byte_en_q;
  logic [1:0]             lane_cnt;
  logic                   flush_pending;
  logic                   overflow_q;

  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   push;
  logic                   pop;
  logic                   accept;
  logic                   flush_close;
  logic                   flush_idle;

  // FIFO status. A byte arriving at a full FIFO is dropped even if a pop
  // frees a slot in the same cycle, which keeps push independent of pop.
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
  assign push       = valid_i && !fifo_full;
  assign rd_data    = fifo_mem[rd_ptr];
  assign accept     = valid_o && ready_i;

  // FSM state register.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic. IDLE always has lane_cnt 0, so its first pop can
  // never complete a word. A flush closes a partial word only once the FIFO
  // has drained, so buffered bytes go out ahead of the partial word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (pop && (lane_cnt == 2'd3)) begin
          state_d = HOLD;
        end else if (flush_close) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs. Pops stop while a word is held so the presented word cannot
  // change underneath the consumer.
  always_comb begin
    valid_o     = 1'b0;
    pop         = 1'b0;
    flush_close = 1'b0;
    flush_idle  = 1'b0;
    case (state_q)
      IDLE: begin
        pop        = !fifo_empty;
        flush_idle = flush_pending && fifo_empty;
      end
      FILL: begin
        pop         = !fifo_empty;
        flush_close = flush_pending && fifo_empty;
      end
      HOLD: begin
        valid_o = 1'b1;
      end
      default: begin
        valid_o = 1'b0;
      end
    endcase
  end

  // FIFO pointers and level. Pointers are exactly PTR_W bits wide, so they
  // wrap modulo FIFO_DEPTH on their own.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level <= level + LVL_W'(1);
      end else if (!push && pop) begin
        level <= level - LVL_W'(1);
      end
    end
  end

  // FIFO storage needs no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_mem[wr_ptr] <= data_i;
    end
  end

  // Lane assembly. The word register is cleared on acceptance so lanes a
  // later flush leaves unfilled read as zero. A flushed word resets
  // lane_cnt so the next word starts in lane 0 again.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      word_q    <= '0;
      byte_en_q <= '0;
      lane_cnt  <= '0;
    end else if (accept) begin
      word_q    <= '0;
      byte_en_q <= '0;
      lane_cnt  <= '0;
    end else if (pop) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_cnt == 2'(k)) begin
          word_q[k*SYS_DWIDTH +: SYS_DWIDTH] <= rd_data;
          byte_en_q[k]                       <= 1'b1;
        end
      end
      lane_cnt <= lane_cnt + 2'd1;
    end else if (flush_close) begin
      lane_cnt <= '0;
    end
  end

  // Flush request latch. A pulse arriving while a request is already pending
  // has nothing extra to do, and the clear takes priority over a new pulse.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      flush_pending <= 1'b0;
    end else if (flush_close || flush_idle) begin
      flush_pending <= 1'b0;
    end else if (flush_i) begin
      flush_pending <= 1'b1;
    end
  end

  // Sticky overflow flag; only reset clears it.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (valid_i && fifo_full) begin
      overflow_q <= 1'b1;
    end
  end

  assign data_o    = word_q;
  assign byte_en_o = byte_en_q;
  assign overflow  = overflow_q;

`ifdef BYTE_PACKER_LEVEL_EN
  assign fifo_level = level;
`endif

endmodule

// File: tb/tb_byte_packer.sv
// ---------------------------------------------------------------------------
// tb_byte_packer
//
// Self-checking bench for byte_packer. A queue-based model of the packer
// (byte FIFO contents, bytes collected for the current word, hold/flush/
// overflow flags) is stepped on every rising edge and compared against the
// DUT on every falling edge. Directed scenarios add hand-computed literal
// expectations for words, latency, overflow and reset behaviour.
// ---------------------------------------------------------------------------
module tb_byte_packer;

  localparam int SYS_DWIDTH = 8;
  localparam int MST_DWIDTH = 32;
  localparam int FIFO_DEPTH = 16;

  logic                        clk_sys;
  logic                        rst_n;
  logic [SYS_DWIDTH-1:0]       data_i;
  logic                        valid_i;
  logic                        flush_i;
  logic [MST_DWIDTH-1:0]       data_o;
  logic [3:0]                  byte_en_o;
  logic                        valid_o;
  logic                        ready_i;
  logic                        overflow;
`ifdef BYTE_PACKER_LEVEL_EN
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  byte_packer #(
    .SYS_DWIDTH (SYS_DWIDTH),
    .MST_DWIDTH (MST_DWIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .flush_i    (flush_i),
    .data_o     (data_o),
    .byte_en_o  (byte_en_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
`ifdef BYTE_PACKER_LEVEL_EN
    .fifo_level (fifo_level),
`endif
    .overflow   (overflow)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Every comparison goes through here.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, changed on the falling edge.
  task automatic applyStimulus(input logic [7:0] b, input logic v,
                               input logic fl, input logic rdy);
    @(negedge clk_sys);
    data_i  = b;
    valid_i = v;
    flush_i = fl;
    ready_i = rdy;
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_fifo[$];
  logic [7:0] m_word[$];
  bit         m_hold;
  bit         m_flush;
  bit         m_ovf;
  int         m_drops;
  bit         model_on = 1'b0;

  // Model step: a held word waits for ready; otherwise one byte moves from
  // the FIFO into the word, and a pending flush on an empty FIFO either
  // closes the partial word or is simply dropped if no bytes are collected.
  always @(posedge clk_sys) begin
    bit was_full;
    bit clear_flush;
    if (!rst_n) begin
      m_fifo.delete();
      m_word.delete();
      m_hold   = 1'b0;
      m_flush  = 1'b0;
      m_ovf    = 1'b0;
      m_drops  = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      was_full    = (m_fifo.size() == FIFO_DEPTH);
      clear_flush = 1'b0;
      if (m_hold) begin
        if (ready_i) begin
          m_hold = 1'b0;
          m_word.delete();
        end
      end else if (m_fifo.size() > 0) begin
        m_word.push_back(m_fifo.pop_front());
        if (m_word.size() == 4) m_hold = 1'b1;
      end else if (m_flush) begin
        clear_flush = 1'b1;
        if (m_word.size() > 0) m_hold = 1'b1;
      end
      if (valid_i) begin
        if (was_full) begin
          m_ovf = 1'b1;
          m_drops++;
        end else begin
          m_fifo.push_back(data_i);
        end
      end
      if (clear_flush) m_flush = 1'b0;
      else if (flush_i) m_flush = 1'b1;
    end
  end

  function automatic logic [31:0] model_data();
    logic [31:0] w = '0;
    for (int k = 0; k < m_word.size(); k++) w[k*8 +: 8] = m_word[k];
    return w;
  endfunction

  function automatic logic [3:0] model_ben();
    logic [3:0] be = '0;
    for (int k = 0; k < m_word.size(); k++) be[k] = 1'b1;
    return be;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk_sys) begin
    if (model_on) begin
      checkOutput("valid_o", 64'(valid_o), 64'(m_hold));
      checkOutput("overflow", 64'(overflow), 64'(m_ovf));
      if (m_hold) begin
        checkOutput("data_o", 64'(data_o), 64'(model_data()));
        checkOutput("byte_en_o", 64'(byte_en_o), 64'(model_ben()));
      end
`ifdef BYTE_PACKER_LEVEL_EN
      checkOutput("fifo_level", 64'(fifo_level), 64'(m_fifo.size()));
`endif
    end
  end

  // Record every word the consumer accepts.
  logic [31:0] got_data[$];
  logic [3:0]  got_ben[$];
  always @(posedge clk_sys) begin
    if (rst_n && valid_o && ready_i) begin
      got_data.push_back(data_o);
      got_ben.push_back(byte_en_o);
    end
  end

  task automatic idle_cycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b0, 1'b0, rdy);
  endtask

  task automatic pulse_reset();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
  endtask

  // Idle cycles until valid_o is seen; cycles counts falling edges waited.
  task automatic wait_word(input logic rdy, input int budget, output int cycles);
    bit seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      applyStimulus(8'h00, 1'b0, 1'b0, rdy);
      cycles++;
      if (valid_o === 1'b1) seen = 1'b1;
    end
    if (!seen) checkOutput("word_timeout", 64'd0, 64'd1);
  endtask

  task automatic collect_words(input int n, input int budget);
    int c = 0;
    while (got_data.size() < n && c < budget) begin
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
      c++;
    end
    if (got_data.size() < n) checkOutput("words_timeout", 64'(got_data.size()), 64'(n));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    int nvalid;
    rst_n   = 1'b0;
    data_i  = '0;
    valid_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b0;
    idle_cycles(2, 1'b1);
    rst_n = 1'b1;

    // Reset state.
    checkOutput("rst_data_o", 64'(data_o), 64'h0);
    checkOutput("rst_byte_en", 64'(byte_en_o), 64'h0);
    checkOutput("rst_valid_o", 64'(valid_o), 64'h0);
    checkOutput("rst_overflow", 64'(overflow), 64'h0);
    idle_cycles(2, 1'b1);

    // Full word, latency and single-cycle valid.
    $display("[TB] scenario: full word");
    applyStimulus(8'h11, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h22, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h33, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h44, 1'b1, 1'b0, 1'b1);
    wait_word(1'b1, 10, cyc);
    checkOutput("s1_latency", 64'(cyc), 64'd2);
    checkOutput("s1_data", 64'(data_o), 64'h44332211);
    checkOutput("s1_ben", 64'(byte_en_o), 64'hF);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("s1_valid_one_cycle", 64'(valid_o), 64'h0);
    idle_cycles(3, 1'b1);

    // Partial flush.
    $display("[TB] scenario: partial flush");
    applyStimulus(8'hAA, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'hBB, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1);
    wait_word(1'b1, 10, cyc);
    checkOutput("s2_data", 64'(data_o), 64'h0000BBAA);
    checkOutput("s2_ben", 64'(byte_en_o), 64'h3);
    idle_cycles(2, 1'b1);
    checkOutput("s2_flush_cleared", 64'(dut.flush_pending), 64'h0);
    idle_cycles(2, 1'b1);

    // Empty flush produces nothing.
    $display("[TB] scenario: empty flush");
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1);
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
      if (valid_o !== 1'b0) nvalid++;
    end
    checkOutput("s3_no_valid", 64'(nvalid), 64'd0);

    // Backpressure: held word stays stable.
    $display("[TB] scenario: backpressure");
    got_data.delete();
    got_ben.delete();
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i), 1'b1, 1'b0, 1'b0);
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
      if (valid_o === 1'b1 && data_o !== 32'h04030201) nvalid++;
    end
    checkOutput("s4_hold_stable", 64'(nvalid), 64'd0);
    checkOutput("s4_hold_valid", 64'(valid_o), 64'h1);
    collect_words(2, 40);
    if (got_data.size() >= 2) begin
      checkOutput("s4_word0", 64'(got_data[0]), 64'h04030201);
      checkOutput("s4_word1", 64'(got_data[1]), 64'h08070605);
    end
    checkOutput("s4_no_overflow", 64'(overflow), 64'h0);
    idle_cycles(3, 1'b1);

    // Overflow: FIFO_DEPTH+4+1 bytes while the consumer stalls.
    $display("[TB] scenario: overflow");
    pulse_reset();
    got_data.delete();
    got_ben.delete();
    for (int i = 0; i < FIFO_DEPTH + 5; i++) applyStimulus(8'(8'h80 + i), 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("s5_overflow", 64'(overflow), 64'h1);
    checkOutput("s5_model_drops", 64'(m_drops), 64'd1);
    collect_words(5, 60);
    idle_cycles(10, 1'b1);
    checkOutput("s5_word_count", 64'(got_data.size()), 64'd5);
    if (got_data.size() >= 5) begin
      checkOutput("s5_first_word", 64'(got_data[0]), 64'h83828180);
      checkOutput("s5_last_word", 64'(got_data[4]), 64'h93929190);
    end
    checkOutput("s5_overflow_sticky", 64'(overflow), 64'h1);
    pulse_reset();
    checkOutput("s5_overflow_cleared", 64'(overflow), 64'h0);

    // Reset mid-operation discards partial bytes.
    $display("[TB] scenario: reset mid-operation");
    applyStimulus(8'h01, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h02, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h03, 1'b1, 1'b0, 1'b1);
    pulse_reset();
    checkOutput("s6_data_cleared", 64'(data_o), 64'h0);
    checkOutput("s6_ben_cleared", 64'(byte_en_o), 64'h0);
    got_data.delete();
    got_ben.delete();
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'h5A + i), 1'b1, 1'b0, 1'b1);
    collect_words(1, 20);
    idle_cycles(10, 1'b1);
    checkOutput("s6_word_count", 64'(got_data.size()), 64'd1);
    if (got_data.size() >= 1) checkOutput("s6_word", 64'(got_data[0]), 64'h5D5C5B5A);

    // Flush during drain: full word first, then the partial remainder.
    $display("[TB] scenario: flush during drain");
    got_data.delete();
    got_ben.delete();
    for (int i = 0; i < 6; i++) applyStimulus(8'(8'hC0 + i), 1'b1, (i == 1), 1'b1);
    collect_words(2, 30);
    idle_cycles(5, 1'b1);
    checkOutput("s7_word_count", 64'(got_data.size()), 64'd2);
    if (got_data.size() >= 2) begin
      checkOutput("s7_word0", 64'(got_data[0]), 64'hC3C2C1C0);
      checkOutput("s7_ben0", 64'(got_ben[0]), 64'hF);
      checkOutput("s7_word1", 64'(got_data[1]), 64'h0000C5C4);
      checkOutput("s7_ben1", 64'(got_ben[1]), 64'h3);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/byte_packer.md
BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 The block SHALL have parameter SYS_DWIDTH, default 8, meaning the input byte width.
REQ-002 The block SHALL have parameter MST_DWIDTH, default 32, meaning the output word width; it is fixed at 4*SYS_DWIDTH.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, meaning the byte FIFO entry count; it is a power of 2 and at least 4.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 Port clk_sys, input, 1 bit: system clock; all logic on its rising edge.
REQ-006 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-007 Port data_i, input, SYS_DWIDTH bits: decrypted byte from the decryption top-level data_o.
REQ-008 Port valid_i, input, 1 bit: data_i valid this cycle; this port has no backpressure.
REQ-009 Port flush_i, input, 1 bit: one-cycle pulse requesting emission of a partial word.
REQ-010 Port data_o, output, MST_DWIDTH bits: packed word; byte k is at [8k+7:8k], and the first received byte is in lane 0.
REQ-011 Port byte_en_o, output, 4 bits: bit k is 1 when lane k of data_o holds a valid byte.
REQ-012 Port valid_o, output, 1 bit: data_o/byte_en_o valid.
REQ-013 Port ready_i, input, 1 bit: consumer accepts the word when valid_o && ready_i.
REQ-014 Port overflow, output, 1 bit: sticky flag; a byte was dropped.

Function
REQ-015 Accepted bytes SHALL be written to a FIFO_DEPTH-entry byte FIFO when valid_i=1 and FIFO level < FIFO_DEPTH.
REQ-016 A byte SHALL be dropped when valid_i=1 and level = FIFO_DEPTH, even if a pop occurs the same cycle; overflow SHALL be set to 1 and hold until reset.
REQ-017 Simultaneous push and pop SHALL leave the level unchanged; the read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 The packer FSM SHALL have three states.
 - IDLE: no lanes filled.
 - FILL: 1-3 lanes filled.
 - HOLD: valid_o=1.
REQ-019 In IDLE and FILL, one byte SHALL be popped per cycle when the FIFO is non-empty.
 - The popped byte is written to lane lane_cnt.
 - lane_cnt (2 bits) is then incremented.
REQ-020 When the 4th lane is written, the FSM SHALL enter HOLD with byte_en_o=4'b1111 and lane_cnt=0.
REQ-021 With back-to-back input bytes and an empty FIFO, valid_o SHALL rise 2 cycles after the cycle in which the 4th byte's valid_i=1.
REQ-022 In HOLD, no pop SHALL occur; data_o and byte_en_o SHALL be stable until valid_o && ready_i.
REQ-023 On acceptance, the FSM SHALL go to IDLE next cycle with valid_o=0; a new pop may occur in that next cycle.
REQ-024 A flush_i pulse SHALL set flush_pending; a pulse while flush_pending=1 SHALL have no extra effect.
REQ-025 When flush_pending=1, the FIFO is empty and the state is FILL, the FSM SHALL enter HOLD next cycle.
 - byte_en_o has ones in the filled lanes only.
 - Unfilled lanes of data_o are 0.
 - flush_pending is cleared.
REQ-026 When flush_pending=1, the FIFO is empty and the state is IDLE, flush_pending SHALL clear with no output word.
REQ-027 A flush request SHALL be recognised in every state, including HOLD and while the FIFO drains.
REQ-028 Bytes arriving before the FIFO empties SHALL be included in the flushed output, in full words first and then the partial word.

Reset
REQ-029 When rst_n=0 at a clock edge, the block SHALL reset the following:
 - data_o = 0
 - byte_en_o = 0
 - valid_o = 0
 - overflow = 0
 - FSM to IDLE
 - lane_cnt, the FIFO pointers and the level to 0
 - flush_pending = 0
REQ-030 Reset mid-operation SHALL discard all buffered and partially packed bytes without emitting them.

Configuration
REQ-031 With macro BYTE_PACKER_LEVEL_EN defined, the block SHALL add output port fifo_level, width $clog2(FIFO_DEPTH)+1.
 - It carries the registered FIFO occupancy.
 - Its reset value is 0.
 - Without the macro, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Scenario full words: bytes 0x11,0x22,0x33,0x44 on 4 consecutive cycles with ready_i=1 -> data_o=0x44332211 and byte_en_o=4'hF, with valid_o high for 1 cycle, 2 cycles after the 4th byte.
REQ-033 Scenario partial flush: bytes 0xAA,0xBB, then a flush_i pulse -> data_o=0x0000BBAA and byte_en_o=4'b0011; flush_pending then clears.
REQ-034 Scenario empty flush: flush_i in IDLE with the FIFO empty -> no valid_o within 10 cycles.
REQ-035 Scenario backpressure: 8 bytes 0x01..0x08 with ready_i=0 for 20 cycles, then ready_i=1 -> word 0x04030201 is held stable throughout, then 0x08070605 follows; no overflow.
REQ-036 Scenario overflow: ready_i=0 and FIFO_DEPTH+4+1 bytes sent -> overflow=1 and exactly 1 byte dropped; overflow stays 1 until rst_n=0.
REQ-037 Scenario reset mid-operation: 3 bytes pushed, rst_n=0 for 1 cycle, then 4 bytes 0x5A..0x5D -> first word=0x5D5C5B5A.
